// File: rtl/gshare_pred.sv
`default_nettype none
// ============================================================================
//  Module   : gshare_pred
//  Purpose  : gshare branch predictor. A PHT of 2-bit counters indexed by
//             PC XOR global history, a tagged BTB holding {valid, uncond,
//             tag, target}, and a speculative GHR that is repaired from the
//             snapshot returned by EX on a mispredict. After reset or flush a
//             hardware walker clears the tables before the predictor goes live.
//  Ports    : clk_i/rstn_i        clock, async active-low reset
//             flush_i             re-run table initialisation
//             pcF_i, fetch_ena_i  fetch PC and fetch-advance strobe
//             predF_*_o           prediction and GHR snapshot for fetch
//             updE_*_i            resolved branch/jump information from EX
//             ready_o             tables initialised, predictor active
//  Revision : 1.0 - initial release
// ============================================================================
module gshare_pred #(
    parameter int         XLEN     = 32,
    parameter int         PHT_SIZE = 1024,
    parameter int         BTB_SIZE = 256,
    parameter int         GHR_LEN  = 8,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                flush_i,
    input  logic [XLEN-1:0]     pcF_i,
    input  logic                fetch_ena_i,
    output logic                predF_taken_o,
    output logic [XLEN-1:0]     predF_target_o,
    output logic [GHR_LEN-1:0]  predF_ghr_o,
    input  logic                updE_valid_i,
    input  logic                updE_is_cond_i,
    input  logic [XLEN-1:0]     updE_pc_i,
    input  logic                updE_taken_i,
    input  logic [XLEN-1:0]     updE_target_i,
    input  logic [GHR_LEN-1:0]  updE_ghr_i,
    input  logic                updE_mispred_i,
    output logic                ready_o
);

    localparam int PI       = $clog2(PHT_SIZE);
    localparam int BI       = $clog2(BTB_SIZE);
    localparam int TW       = XLEN - BI - 1;
    localparam int MAXN     = (PHT_SIZE > BTB_SIZE) ? PHT_SIZE : BTB_SIZE;
    // One spare bit so the walker can be compared against either table size.
    localparam int WW       = $clog2(MAXN) + 1;
    localparam logic [WW-1:0] WALK_LAST = WW'(MAXN - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e               state_q;
    logic [WW-1:0]        walk_q;
    logic [GHR_LEN-1:0]   ghr_q;
    logic [GHR_LEN-1:0]   ghr_d;
    logic                 ready_q;

    // Tables: no reset, contents defined only by the init walker.
    logic [1:0]           pht_q       [PHT_SIZE];
    logic                 btb_valid_q [BTB_SIZE];
    logic                 btb_uncond_q[BTB_SIZE];
    logic [TW-1:0]        btb_tag_q   [BTB_SIZE];
    logic [XLEN-1:0]      btb_tgt_q   [BTB_SIZE];

    // ---------------- Fetch-side lookup ----------------
    logic [PI-1:0]        w_rd_pht_idx;
    logic [BI-1:0]        w_rd_btb_idx;
    logic                 w_hit;
    logic                 w_uncond;
    logic                 w_pred_taken;

    assign w_rd_pht_idx = pcF_i[PI:1] ^ PI'(ghr_q);
    assign w_rd_btb_idx = pcF_i[BI:1];
    assign w_uncond     = btb_uncond_q[w_rd_btb_idx];
    assign w_hit        = ready_q & btb_valid_q[w_rd_btb_idx]
                        & (btb_tag_q[w_rd_btb_idx] == pcF_i[XLEN-1:BI+1]);
    assign w_pred_taken = w_hit & (w_uncond | pht_q[w_rd_pht_idx][1]);

    assign predF_taken_o  = w_pred_taken;
    assign predF_target_o = w_hit ? btb_tgt_q[w_rd_btb_idx] : '0;
    assign predF_ghr_o    = ghr_q;
    assign ready_o        = ready_q;

    // ---------------- GHR next state ----------------
    logic [GHR_LEN-1:0]   w_ghr_fetch_shift;
    logic [GHR_LEN-1:0]   w_ghr_repair_shift;

    generate
        if (GHR_LEN == 1) begin : g_ghr_one
            assign w_ghr_fetch_shift  = w_pred_taken;
            assign w_ghr_repair_shift = updE_taken_i;
        end else begin : g_ghr_multi
            assign w_ghr_fetch_shift  = {ghr_q[GHR_LEN-2:0], w_pred_taken};
            assign w_ghr_repair_shift = {updE_ghr_i[GHR_LEN-2:0], updE_taken_i};
        end
    endgenerate

    // Repair from EX outranks the speculative shift of the same cycle.
    always_comb begin
        ghr_d = ghr_q;
        if (ready_q && updE_valid_i && updE_mispred_i) begin
            ghr_d = updE_is_cond_i ? w_ghr_repair_shift : updE_ghr_i;
        end else if (fetch_ena_i && w_hit && !w_uncond) begin
            ghr_d = w_ghr_fetch_shift;
        end
    end

    // ---------------- Update path ----------------
    logic [PI-1:0]        w_upd_pht_idx;
    logic [BI-1:0]        w_upd_btb_idx;
    logic                 w_pht_we;
    logic                 w_btb_we;
    logic [1:0]           w_cnt_cur;
    logic [1:0]           w_cnt_nxt;

    assign w_upd_pht_idx = updE_pc_i[PI:1] ^ PI'(updE_ghr_i);
    assign w_upd_btb_idx = updE_pc_i[BI:1];
    assign w_pht_we      = ready_q & updE_valid_i & updE_is_cond_i;
    assign w_btb_we      = ready_q & updE_valid_i & updE_taken_i;
    assign w_cnt_cur     = pht_q[w_upd_pht_idx];

    always_comb begin
        w_cnt_nxt = w_cnt_cur;
        if (updE_taken_i && (w_cnt_cur != 2'b11)) begin
            w_cnt_nxt = w_cnt_cur + 2'b01;
        end else if (!updE_taken_i && (w_cnt_cur != 2'b00)) begin
            w_cnt_nxt = w_cnt_cur - 2'b01;
        end
    end

    // Bit 0 of the PCs is never part of an index or tag.
    logic w_unused_ok;
    assign w_unused_ok = ^{pcF_i[0], updE_pc_i[0]};

    // ---------------- Control FSM ----------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_INIT;
            walk_q  <= '0;
            ghr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    ghr_q <= '0;
                    if (flush_i) begin
                        walk_q <= '0;
                    end else if (walk_q == WALK_LAST) begin
                        walk_q  <= '0;
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        walk_q <= walk_q + 1'b1;
                    end
                end
                default: begin
                    if (flush_i) begin
                        state_q <= ST_INIT;
                        walk_q  <= '0;
                        ghr_q   <= '0;
                        ready_q <= 1'b0;
                    end else begin
                        ghr_q <= ghr_d;
                    end
                end
            endcase
        end
    end

    // ---------------- Table writes ----------------
    always_ff @(posedge clk_i) begin
        if (state_q == ST_INIT) begin
            if (walk_q < WW'(PHT_SIZE)) begin
                pht_q[walk_q[PI-1:0]] <= CNT_INIT;
            end
            if (walk_q < WW'(BTB_SIZE)) begin
                btb_valid_q[walk_q[BI-1:0]] <= 1'b0;
            end
        end else begin
            if (w_pht_we) begin
                pht_q[w_upd_pht_idx] <= w_cnt_nxt;
            end
            if (w_btb_we) begin
                btb_valid_q [w_upd_btb_idx] <= 1'b1;
                btb_uncond_q[w_upd_btb_idx] <= ~updE_is_cond_i;
                btb_tag_q   [w_upd_btb_idx] <= updE_pc_i[XLEN-1:BI+1];
                btb_tgt_q   [w_upd_btb_idx] <= updE_target_i;
            end
        end
    end

endmodule
`default_nettype wire
